// File: rtl/soc_irq_ctrl_pkg.sv
// Shared constants for the SoC interrupt controller: register map and bit positions.
package soc_irq_ctrl_pkg;

    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned MAX_IRQ = 16;

    localparam logic [ADDR_W-1:0] ADDR_STATUS  = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_PENDING = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_ENABLE  = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_MODE    = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_VECTOR  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_ACK     = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_FORCE   = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_CTRL    = 3'd7;

    localparam int unsigned CTRL_GIE_BIT     = 0;
    localparam int unsigned VECTOR_VALID_BIT = 15;

endpackage

// File: rtl/soc_irq_sync_edge.sv
// Vector-wide multi-flop synchroniser with a one-cycle delayed copy for rising-edge detect.
module soc_irq_sync_edge #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] irq_i,
    output logic [WIDTH-1:0] s_o,
    output logic [WIDTH-1:0] rise_c_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prv_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prv_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
            prv_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s_o      = sync_q[SYNC_STAGES-1];
    assign rise_c_o = sync_q[SYNC_STAGES-1] & ~prv_q;

endmodule

// File: rtl/soc_irq_ctrl.sv
// Avalon-MM interrupt controller: per-source level/edge pending latch, masking,
// global enable, priority vector and a registered CPU interrupt line.
module soc_irq_ctrl
    import soc_irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq_out
);

    localparam int unsigned N = NUM_IRQ;

    if (NUM_IRQ < 1 || NUM_IRQ > MAX_IRQ) begin : g_bad_num_irq
        $error("NUM_IRQ out of range");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("SYNC_STAGES out of range");
    end

    logic [N-1:0]      sync_s;
    logic [N-1:0]      rise_c;
    logic [N-1:0]      pending_q, pending_d;
    logic [N-1:0]      enable_q;
    logic [N-1:0]      mode_q;
    logic              gie_q;
    logic [DATA_W-1:0] readdata_q;
    logic              irq_out_q;

    logic              wr_c;
    logic              wr_pending_c, wr_enable_c, wr_mode_c, wr_ack_c, wr_force_c, wr_ctrl_c;
    logic [N-1:0]      clr_c, force_c, active_c;
    logic [IDX_W-1:0]  vec_idx_c;
    logic [DATA_W-1:0] rd_data_c;
    logic              unused_c;

    soc_irq_sync_edge #(
        .WIDTH       (N),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .irq_i    (irq_in),
        .s_o      (sync_s),
        .rise_c_o (rise_c)
    );

    assign wr_c         = chipselect && !write_n;
    assign wr_pending_c = wr_c && (address == ADDR_PENDING);
    assign wr_enable_c  = wr_c && (address == ADDR_ENABLE);
    assign wr_mode_c    = wr_c && (address == ADDR_MODE);
    assign wr_ack_c     = wr_c && (address == ADDR_ACK);
    assign wr_force_c   = wr_c && (address == ADDR_FORCE);
    assign wr_ctrl_c    = wr_c && (address == ADDR_CTRL);

    // ACK indices beyond the source count shift the one-hot out of range and clear nothing
    assign clr_c   = (wr_pending_c ? writedata[N-1:0] : '0)
                   | (wr_ack_c ? (N'(1) << writedata[IDX_W-1:0]) : '0);
    assign force_c = wr_force_c ? writedata[N-1:0] : '0;

    // Edge sources: set beats clear so a coincident event is never dropped
    assign pending_d = (mode_q & ((pending_q & ~clr_c) | rise_c | force_c))
                     | (~mode_q & sync_s);

    assign active_c = pending_q & enable_q;

    // Lowest active index wins
    always_comb begin
        vec_idx_c = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (active_c[i]) vec_idx_c = IDX_W'(i);
        end
    end

    always_comb begin
        rd_data_c = '0;
        case (address)
            ADDR_STATUS:  rd_data_c = DATA_W'(active_c);
            ADDR_PENDING: rd_data_c = DATA_W'(pending_q);
            ADDR_ENABLE:  rd_data_c = DATA_W'(enable_q);
            ADDR_MODE:    rd_data_c = DATA_W'(mode_q);
            ADDR_VECTOR: begin
                rd_data_c[VECTOR_VALID_BIT] = |active_c;
                rd_data_c[IDX_W-1:0]        = vec_idx_c;
            end
            ADDR_CTRL:    rd_data_c[CTRL_GIE_BIT] = gie_q;
            default:      rd_data_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            gie_q      <= 1'b0;
            readdata_q <= '0;
            irq_out_q  <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            if (wr_enable_c) enable_q <= writedata[N-1:0];
            if (wr_mode_c)   mode_q   <= writedata[N-1:0];
            if (wr_ctrl_c)   gie_q    <= writedata[CTRL_GIE_BIT];
            readdata_q <= rd_data_c;
            irq_out_q  <= gie_q & (|active_c);
        end
    end

    assign readdata = readdata_q;
    assign irq_out  = irq_out_q;

    // Upper writedata bits are don't-care for narrower source counts
    assign unused_c = ^writedata;

endmodule
